// File: rtl/fixp2fp_norm.sv
// Signed fixed-point to IEEE-754 single-precision converter.
// Three-stage elastic pipeline: sign/magnitude, leading-zero count, pack/round-to-nearest-even.
module fixp2fp_norm #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int USER_WIDTH = 16
) (
  input  logic                  axis_aclk,
  input  logic                  axis_aresetn,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  m_axis_tlast
);
  localparam int LZ_W   = $clog2(DATA_WIDTH);
  localparam int EXT_W  = DATA_WIDTH + 24;
  localparam int E_BASE = 127 + DATA_WIDTH - 1 - FRAC_BITS;

  // Smallest exponent occurs at lz = DATA_WIDTH-1, largest at lz = 0 (no carry possible there).
  if ((127 - FRAC_BITS) < 1 || E_BASE > 254) begin : g_param_check
    $error("fixp2fp_norm: DATA_WIDTH/FRAC_BITS give an exponent outside 1..254");
  end

  logic                  v1_reg, v2_reg, v3_reg;
  logic                  load1, load2, load3, accept;

  logic                  sign1_reg, last1_reg;
  logic [DATA_WIDTH-1:0] mag1_reg;
  logic [USER_WIDTH-1:0] user1_reg;

  logic                  sign2_reg, nz2_reg, last2_reg;
  logic [DATA_WIDTH-1:0] mag2_reg;
  logic [LZ_W-1:0]       lz2_reg;
  logic [USER_WIDTH-1:0] user2_reg;

  logic [31:0]           data3_reg;
  logic [USER_WIDTH-1:0] user3_reg;
  logic                  last3_reg;

  assign load3         = !v3_reg || m_axis_tready;
  assign load2         = !v2_reg || load3;
  assign load1         = !v1_reg || load2;
  assign s_axis_tready = axis_aresetn && load1;
  assign accept        = s_axis_tvalid && s_axis_tready;

  // Stage 1: sign and magnitude; the most-negative input maps to 2^(DATA_WIDTH-1) unsigned.
  logic [DATA_WIDTH-1:0] mag_next;
  assign mag_next = s_axis_tdata[DATA_WIDTH-1] ? (~s_axis_tdata + DATA_WIDTH'(1)) : s_axis_tdata;

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      v1_reg    <= 1'b0;
      sign1_reg <= 1'b0;
      mag1_reg  <= '0;
      user1_reg <= '0;
      last1_reg <= 1'b0;
    end else if (load1) begin
      v1_reg <= accept;
      if (accept) begin
        sign1_reg <= s_axis_tdata[DATA_WIDTH-1];
        mag1_reg  <= mag_next;
        user1_reg <= s_axis_tuser;
        last1_reg <= s_axis_tlast;
      end
    end
  end

  // Stage 2: leading-zero count (highest set bit wins).
  int              lz_int;
  logic [LZ_W-1:0] lz_next;

  always_comb begin
    lz_int = DATA_WIDTH;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (mag1_reg[i]) lz_int = DATA_WIDTH - 1 - i;
    end
    lz_next = LZ_W'(lz_int);
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      v2_reg    <= 1'b0;
      sign2_reg <= 1'b0;
      nz2_reg   <= 1'b0;
      mag2_reg  <= '0;
      lz2_reg   <= '0;
      user2_reg <= '0;
      last2_reg <= 1'b0;
    end else if (load2) begin
      v2_reg <= v1_reg;
      if (v1_reg) begin
        sign2_reg <= sign1_reg;
        nz2_reg   <= |mag1_reg;
        mag2_reg  <= mag1_reg;
        lz2_reg   <= lz_next;
        user2_reg <= user1_reg;
        last2_reg <= last1_reg;
      end
    end
  end

  // Stage 3: normalise, round to nearest even, pack. Zero padding supplies absent low bits.
  logic [DATA_WIDTH-1:0] norm;
  logic [EXT_W-1:0]      ext;
  logic [22:0]           mant;
  logic                  guard, sticky, round_up;
  logic [23:0]           mant_sum;
  logic signed [8:0]     exp_next;
  logic [31:0]           result_next;

  always_comb begin
    norm        = mag2_reg << lz2_reg;
    ext         = {norm, 24'd0};
    mant        = ext[EXT_W-2 -: 23];
    guard       = ext[DATA_WIDTH-1];
    sticky      = |ext[DATA_WIDTH-2:0];
    round_up    = guard && (sticky || mant[0]);
    mant_sum    = {1'b0, mant} + 24'(round_up);
    exp_next    = 9'(E_BASE) - 9'(lz2_reg) + 9'(mant_sum[23]);
    result_next = nz2_reg ? {sign2_reg, exp_next[7:0], mant_sum[22:0]} : 32'd0;
  end

  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      v3_reg    <= 1'b0;
      data3_reg <= '0;
      user3_reg <= '0;
      last3_reg <= 1'b0;
    end else if (load3) begin
      v3_reg <= v2_reg;
      if (v2_reg) begin
        data3_reg <= result_next;
        user3_reg <= user2_reg;
        last3_reg <= last2_reg;
      end
    end
  end

  assign m_axis_tvalid = v3_reg;
  assign m_axis_tdata  = data3_reg;
  assign m_axis_tuser  = user3_reg;
  assign m_axis_tlast  = last3_reg;

endmodule

// File: tb/tb_fixp2fp_norm.sv
// Bench for fixp2fp_norm (Q15.16 in, float out): arithmetic reference model plus
// scoreboard, directed vectors, backpressure, mid-stream reset and random streams.
module tb_fixp2fp_norm;
  logic        clk;
  logic        rst_n;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_data;
  logic [15:0] s_user;
  logic        m_valid, m_ready, m_last;
  logic [31:0] m_data;
  logic [15:0] m_user;

  fixp2fp_norm #(.DATA_WIDTH(32), .FRAC_BITS(16), .USER_WIDTH(16)) dut (
    .axis_aclk     (clk),
    .axis_aresetn  (rst_n),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tuser  (s_user),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tuser  (m_user),
    .m_axis_tlast  (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit check_lat = 0;

  typedef struct {
    logic [31:0] d;
    logic [15:0] u;
    logic        l;
    int          c;
  } exp_t;
  exp_t exp_q[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Value = x / 2^16 rounded to nearest-even single precision, via integer arithmetic.
  function automatic logic [31:0] ref_fp(input logic [31:0] x);
    longint signed   v;
    longint unsigned mag, q, rem, half;
    int              p, shift;
    logic            s;
    v = longint'($signed(x));
    s = (v < 0);
    mag = s ? longint'(-v) : longint'(v);
    if (mag == 0) return 32'd0;
    p = 0;
    for (int i = 0; i < 40; i++) if (mag >= (64'd1 << i)) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      shift = p - 23;
      q     = mag >> shift;
      rem   = mag - (q << shift);
      half  = 64'd1 << (shift - 1);
      if (rem > half || (rem == half && q[0])) q++;
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        p++;
      end
    end
    return {s, 8'(p - 16 + 127), q[22:0]};
  endfunction

  // Scoreboard and stability monitor, sampled on the falling edge.
  logic        held_v = 0;
  logic [48:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      held_v = 0;
    end else begin
      if (held_v) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_hold", 64'({m_data, m_user, m_last}), 64'(held));
      end
      held_v = m_valid && !m_ready;
      held   = {m_data, m_user, m_last};
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got tdata=0x%08h with nothing outstanding, expected no output", m_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          $display("tx cyc=%0d tdata=%08h tuser=%04h tlast=%0d exp=%08h", cyc, m_data, m_user, m_last, e.d);
          chk("tdata", 64'(m_data), 64'(e.d));
          chk("tuser", 64'(m_user), 64'(e.u));
          chk("tlast", 64'(m_last), 64'(e.l));
          if (check_lat) chk("latency", 64'(cyc - e.c), 64'd3);
        end
      end
      if (s_valid && s_ready) begin
        exp_t n;
        n.d = ref_fp(s_data);
        n.u = s_user;
        n.l = s_last;
        n.c = cyc;
        exp_q.push_back(n);
      end
    end
  end

  // Entry and exit at posedge+1.
  task automatic send(input logic [31:0] d, input logic [15:0] u, input logic l);
    bit ok;
    ok = 0;
    s_valid = 1; s_data = d; s_user = u; s_last = l;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1;
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: got s_axis_tready=0 for 200 cycles, required acceptance");
    end
    s_valid = 0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 4))
      0: rnd_word = w;
      1: rnd_word = w >> $urandom_range(0, 31);
      2: rnd_word = -(w >> $urandom_range(0, 31));
      3: rnd_word = 32'h0100_0000 | (w & 32'h3FF);
      default: begin
        case ($urandom_range(0, 4))
          0: rnd_word = 32'h8000_0000;
          1: rnd_word = 32'h7FFF_FFFF;
          2: rnd_word = 32'h0000_0000;
          3: rnd_word = 32'h0000_0001;
          default: rnd_word = 32'hFFFF_FFFF;
        endcase
      end
    endcase
  endfunction

  // Hand-computed: in / 65536 rounded to nearest-even single.
  logic [31:0] dir_in  [10] = '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 32'h0000_0001,
                                32'h7FFF_FFFF, 32'h0100_0001, 32'h0100_0003, 32'h0100_0080, 32'hFFFF_FFFF};
  logic [31:0] dir_exp [10] = '{32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 32'hC700_0000, 32'h3780_0000,
                                32'h4700_0000, 32'h4380_0000, 32'h4380_0002, 32'h4380_0040, 32'hB780_0000};

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx;
    int  sent;
    bit  fired;
    rst_n = 0; s_valid = 0; s_data = 0; s_user = 0; s_last = 0; m_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_tdata",   64'(m_data),  64'd0);
    chk("rst_tuser",   64'(m_user),  64'd0);
    chk("rst_tlast",   64'(m_last),  64'd0);
    #2 rst_n = 1;
    @(posedge clk); #1;
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    chk("post_rst_m_valid", 64'(m_valid), 64'd0);

    for (int i = 0; i < 10; i++) chk("model_pin", 64'(ref_fp(dir_in[i])), 64'(dir_exp[i]));

    // Directed vectors back to back at full throughput.
    check_lat = 1;
    for (int i = 0; i < 10; i++) send(dir_in[i], 16'(16'hA000 + i), (i == 9));
    drain();
    check_lat = 0;

    // Backpressure: five offered, three fit before the pipe is full.
    m_ready = 0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      s_valid = 1; s_data = dir_in[idx]; s_user = 16'(16'hB000 + idx); s_last = (idx == 4);
      @(negedge clk); fired = s_ready;
      @(posedge clk); #1;
      if (fired) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'd3);
    chk("bp_s_ready",  64'(s_ready), 64'd0);
    chk("bp_m_valid",  64'(m_valid), 64'd1);
    m_ready = 1;
    while (idx < 5) begin
      send(dir_in[idx], 16'(16'hB000 + idx), (idx == 4));
      idx++;
    end
    drain();

    // Reset with three samples in flight.
    for (int i = 0; i < 3; i++) send(dir_in[i + 3], 16'(16'hC000 + i), 1'b0);
    chk("pre_rst_m_valid", 64'(m_valid), 64'd1);
    #2 rst_n = 0;
    #1;
    chk("async_m_valid", 64'(m_valid), 64'd0);
    chk("async_s_ready", 64'(s_ready), 64'd0);
    chk("async_tdata",   64'(m_data),  64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    @(posedge clk); #1;
    chk("rerst_s_ready", 64'(s_ready), 64'd1);
    chk("rerst_m_valid", 64'(m_valid), 64'd0);
    check_lat = 1;
    for (int i = 6; i < 9; i++) send(dir_in[i], 16'(16'hD000 + i), (i == 8));
    drain();
    check_lat = 0;

    // Random valid/ready toggling.
    sent = 0;
    for (int c = 0; c < 2000 && sent < 250; c++) begin
      if (!s_valid && $urandom_range(0, 2) != 0) begin
        s_valid = 1; s_data = rnd_word(); s_user = 16'($urandom); s_last = 1'($urandom_range(0, 1));
      end
      m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk); fired = s_valid && s_ready;
      @(posedge clk); #1;
      if (fired) begin
        s_valid = 0;
        sent++;
      end
    end
    s_valid = 0;
    m_ready = 1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
